// File: rtl/rgb_pkg.sv
// -----------------------------------------------------------------------------
// rgb_pkg
// Shared types and constants for the RGB LED sharing logic.
//   rgb_t        3-bit colour, packed as {R,G,B}, each bit active-high
//   RGB_*        named colours used by requesters and tests
//   arb_state_t  arbiter state: LED idle or owned by one requester
// -----------------------------------------------------------------------------
package rgb_pkg;

   typedef logic [2:0] rgb_t;

   localparam rgb_t RGB_OFF     = 3'b000;
   localparam rgb_t RGB_RED     = 3'b100;
   localparam rgb_t RGB_YELLOW  = 3'b110;
   localparam rgb_t RGB_GREEN   = 3'b010;
   localparam rgb_t RGB_CYAN    = 3'b011;
   localparam rgb_t RGB_BLUE    = 3'b001;
   localparam rgb_t RGB_MAGENTA = 3'b101;
   localparam rgb_t RGB_WHITE   = 3'b111;

   typedef enum logic {
      ARB_IDLE,
      ARB_OWN
   } arb_state_t;

endpackage

// File: rtl/rgb_rr_pick.sv
// -----------------------------------------------------------------------------
// rgb_rr_pick
// Combinational round-robin picker. Returns the first requester with its req
// bit set, searching upward from (last+1) mod N_REQ and wrapping, so the
// requester at index 'last' is considered only after all others.
// Ports:
//   req    in   N_REQ  candidate request vector
//   last   in   IW     search base (most recent owner)
//   idx    out  IW     index of the chosen requester (0 when none)
//   valid  out  1      at least one candidate present
// -----------------------------------------------------------------------------
module rgb_rr_pick #(
   parameter  int N_REQ = 3,
   localparam int IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    last,
   output logic [IW-1:0]    idx,
   output logic             valid
);

   // Walk offsets from farthest to nearest so the nearest hit after 'last'
   // is the value left standing; this avoids a priority chain with breaks.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first,
      // otherwise paths that skip an assignment infer a latch.
      idx   = '0;
      valid = |req;
      for (int off = N_REQ; off >= 1; off--) begin
         if (req[(int'(last) + off) % N_REQ]) begin
            idx = IW'((int'(last) + off) % N_REQ);
         end
      end
   end

endmodule

// File: rtl/rgb_led_arbiter.sv
// -----------------------------------------------------------------------------
// rgb_led_arbiter
// Shares the on-board RGB LED between N_REQ colour sources. Round-robin grant;
// an owner keeps the LED for at least HOLD_CYCLES cycles before rotation may
// hand it to another requester. Dropping req releases immediately. While owned
// the pins follow the owner's colour live with one cycle of latency.
//
// Optional build macro:
//   RGB_LED_PRIORITY_EN  requester 0 becomes an alert channel: it preempts
//                        any other owner at the next edge, is never rotated
//                        away, and its grants do not advance the rr pointer.
//
// Ports:
//   clk       in   1        system clock
//   rst       in   1        synchronous active-high reset
//   req       in   N_REQ    level request per requester
//   color_in  in   3*N_REQ  {R,G,B} of requester i at [3*i+2:3*i]
//   grant     out  N_REQ    one-hot owner, zero when idle (registered)
//   busy      out  1        LED owned (registered, equals |grant)
//   RGB_R/G/B out  1        LED pins, active-high (registered)
// -----------------------------------------------------------------------------
module rgb_led_arbiter
   import rgb_pkg::*;
#(
   parameter int   N_REQ       = 3,
   parameter int   HOLD_CYCLES = 6000000,
   parameter rgb_t IDLE_COLOR  = RGB_OFF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [3*N_REQ-1:0] color_in,
   output logic [N_REQ-1:0]   grant,
   output logic               busy,
   output logic               RGB_R,
   output logic               RGB_G,
   output logic               RGB_B
);

   localparam int             IW        = $clog2(N_REQ);
   localparam int             CW        = $clog2(HOLD_CYCLES + 1);
   localparam logic [CW-1:0]  HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [IW-1:0]  LAST_IDX  = IW'(N_REQ - 1);

   arb_state_t       state, state_nxt;
   logic [IW-1:0]    owner, owner_nxt;
   logic [IW-1:0]    last, last_nxt;
   logic [CW-1:0]    hold_cnt, hold_nxt;
   logic             prio_own, prio_nxt;   // current ownership came from a priority preempt
   rgb_t             rgb_q;

   logic [N_REQ-1:0] pick_req;
   logic [IW-1:0]    pick_base;
   logic [IW-1:0]    pick_idx;
   logic             pick_valid;
   logic             owner_req;
   logic             hold_done;
   logic             prio_preempt;
   logic             rot_allowed;

   assign owner_req = req[owner];
   assign hold_done = (hold_cnt == HOLD_LAST);

   // The current owner is masked out so a rotation can never re-pick it and
   // "another requester pending" is simply pick_valid. grant is zero in IDLE.
   assign pick_req = req & ~grant;

   // After a priority grant 'last' still names the interrupted requester;
   // starting the search one slot earlier lets that requester resume first.
   assign pick_base = !prio_own   ? last     :
                      (last == '0) ? LAST_IDX : last - 1'b1;

   rgb_rr_pick #(
      .N_REQ (N_REQ)
   ) u_pick (
      .req   (pick_req),
      .last  (pick_base),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

`ifdef RGB_LED_PRIORITY_EN
   assign prio_preempt = (state == ARB_OWN) && req[0] && (owner != '0);
   assign rot_allowed  = (owner != '0);
`else
   assign prio_preempt = 1'b0;
   assign rot_allowed  = 1'b1;
`endif

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      last_nxt  = last;
      hold_nxt  = hold_cnt;
      prio_nxt  = prio_own;
      case (state)
         ARB_IDLE: begin
            if (pick_valid) begin
               state_nxt = ARB_OWN;
               owner_nxt = pick_idx;
               last_nxt  = pick_idx;
               hold_nxt  = '0;
               prio_nxt  = 1'b0;
            end
         end
         ARB_OWN: begin
            if (prio_preempt) begin
               owner_nxt = '0;
               hold_nxt  = '0;
               prio_nxt  = 1'b1;
            end else if (!owner_req) begin
               // Release wins over hold_done; hand over without an idle gap.
               hold_nxt = '0;
               prio_nxt = 1'b0;
               if (pick_valid) begin
                  owner_nxt = pick_idx;
                  last_nxt  = pick_idx;
               end else begin
                  state_nxt = ARB_IDLE;
               end
            end else if (!hold_done) begin
               hold_nxt = hold_cnt + 1'b1;
            end else if (pick_valid && rot_allowed) begin
               owner_nxt = pick_idx;
               last_nxt  = pick_idx;
               hold_nxt  = '0;
               prio_nxt  = 1'b0;
            end
            // Otherwise the owner keeps the LED and hold_cnt stays saturated.
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   // Outputs are computed from the next state so that req sampled at one edge
   // shows on the pins right after that same edge.
   always_ff @(posedge clk) begin
      // NOTE: every register here is plain control state, so all of it is
      // reset; a reset mid-ownership therefore drops the grant at once.
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples pre-edge values regardless of statement order.
         state    <= ARB_IDLE;
         owner    <= '0;
         last     <= LAST_IDX;
         hold_cnt <= '0;
         prio_own <= 1'b0;
         grant    <= '0;
         busy     <= 1'b0;
         rgb_q    <= IDLE_COLOR;
      end else begin
         state    <= state_nxt;
         owner    <= owner_nxt;
         last     <= last_nxt;
         hold_cnt <= hold_nxt;
         prio_own <= prio_nxt;
         if (state_nxt == ARB_OWN) begin
            grant <= N_REQ'(1) << owner_nxt;
            busy  <= 1'b1;
            rgb_q <= color_in[3*owner_nxt +: 3];
         end else begin
            grant <= '0;
            busy  <= 1'b0;
            rgb_q <= IDLE_COLOR;
         end
      end
   end

   assign RGB_R = rgb_q[2];
   assign RGB_G = rgb_q[1];
   assign RGB_B = rgb_q[0];

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rgb_led_arbiter
// Self-checking bench for rgb_led_arbiter with N_REQ=3, HOLD_CYCLES=4.
// Each scenario task drives req/colours cycle by cycle, queues the outputs it
// expects after the next edge, and compares them once that edge has passed.
// The alert-channel scenario runs only when RGB_LED_PRIORITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_rgb_led_arbiter;
   import rgb_pkg::*;

   localparam int N_REQ = 3;
   localparam int HOLD  = 4;

   typedef struct packed {
      logic [2:0] grant;
      logic       busy;
      rgb_t       rgb;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] req;
   rgb_t       col [3];
   logic [8:0] color_in;
   logic [2:0] grant;
   logic       busy;
   logic       RGB_R, RGB_G, RGB_B;

   exp_t exp_q [$];
   int   checks = 0;
   int   errors = 0;

   assign color_in = {col[2], col[1], col[0]};

   always #5 clk = ~clk;

   rgb_led_arbiter #(
      .N_REQ       (N_REQ),
      .HOLD_CYCLES (HOLD),
      .IDLE_COLOR  (RGB_OFF)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .color_in (color_in),
      .grant    (grant),
      .busy     (busy),
      .RGB_R    (RGB_R),
      .RGB_G    (RGB_G),
      .RGB_B    (RGB_B)
   );

   function automatic exp_t mk(input logic [2:0] g, input rgb_t c);
      exp_t e;
      e.grant = g;
      e.busy  = |g;
      e.rgb   = c;
      return e;
   endfunction

   // Advance one clock and land 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      req = 3'b000;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      col[0] = RGB_WHITE; col[1] = RGB_WHITE; col[2] = RGB_WHITE;
      rst = 1'b1;
      req = 3'b111;
      for (int i = 0; i < 5; i++) begin
         // Cycles 0,1: in reset. 2: first grant. 3: reset while owning. 4: idle.
         rst = (i != 2 && i != 4);
         if (i == 4) req = 3'b000;
         exp_q.push_back((i == 2) ? mk(3'b001, RGB_WHITE) : mk(3'b000, RGB_OFF));
         tick();
         e = exp_q.pop_front();
         checks++;
         if (grant !== e.grant || busy !== e.busy || {RGB_R, RGB_G, RGB_B} !== e.rgb) begin
            errors++;
            $display("FAIL reset[%0d]: got grant=%b busy=%b rgb=%b, want grant=%b busy=%b rgb=%b",
                     i, grant, busy, {RGB_R, RGB_G, RGB_B}, e.grant, e.busy, e.rgb);
         end
      end
   endtask

   task automatic test_single();
      exp_t e;
      apply_reset();
      col[0] = RGB_GREEN; col[1] = RGB_RED; col[2] = RGB_BLUE;
      for (int i = 0; i < 22; i++) begin
         req = (i < 21) ? 3'b010 : 3'b000;
         exp_q.push_back((i < 21) ? mk(3'b010, RGB_RED) : mk(3'b000, RGB_OFF));
         tick();
         e = exp_q.pop_front();
         checks++;
         if (grant !== e.grant || busy !== e.busy || {RGB_R, RGB_G, RGB_B} !== e.rgb) begin
            errors++;
            $display("FAIL single[%0d]: got grant=%b busy=%b rgb=%b, want grant=%b busy=%b rgb=%b",
                     i, grant, busy, {RGB_R, RGB_G, RGB_B}, e.grant, e.busy, e.rgb);
         end
      end
   endtask

   task automatic test_rotation();
      exp_t e;
      int   own;
      apply_reset();
      col[0] = RGB_RED; col[1] = RGB_GREEN; col[2] = RGB_BLUE;
      req = 3'b111;
      for (int i = 0; i < 16; i++) begin
         own = (i / HOLD) % N_REQ;
         exp_q.push_back(mk(3'b001 << own, col[own]));
         tick();
         e = exp_q.pop_front();
         checks++;
         if (grant !== e.grant || busy !== e.busy || {RGB_R, RGB_G, RGB_B} !== e.rgb) begin
            errors++;
            $display("FAIL rotation[%0d]: got grant=%b busy=%b rgb=%b, want grant=%b busy=%b rgb=%b",
                     i, grant, busy, {RGB_R, RGB_G, RGB_B}, e.grant, e.busy, e.rgb);
         end
      end
   endtask

   task automatic test_early_release();
      exp_t e;
      apply_reset();
      col[0] = RGB_RED; col[1] = RGB_GREEN; col[2] = RGB_BLUE;
      for (int i = 0; i < 5; i++) begin
         // Owner 0 drops after two cycles of ownership (hold_cnt=1); 2 takes over.
         req = (i < 2) ? 3'b101 : (i < 4) ? 3'b100 : 3'b000;
         exp_q.push_back((i < 2) ? mk(3'b001, RGB_RED) :
                         (i < 4) ? mk(3'b100, RGB_BLUE) : mk(3'b000, RGB_OFF));
         tick();
         e = exp_q.pop_front();
         checks++;
         if (grant !== e.grant || busy !== e.busy || {RGB_R, RGB_G, RGB_B} !== e.rgb) begin
            errors++;
            $display("FAIL early_release[%0d]: got grant=%b busy=%b rgb=%b, want grant=%b busy=%b rgb=%b",
                     i, grant, busy, {RGB_R, RGB_G, RGB_B}, e.grant, e.busy, e.rgb);
         end
      end
   endtask

   task automatic test_live_color();
      exp_t e;
      apply_reset();
      col[0] = RGB_YELLOW; col[1] = RGB_GREEN; col[2] = RGB_BLUE;
      req = 3'b001;
      for (int i = 0; i < 4; i++) begin
         col[0] = (i == 0) ? RGB_YELLOW : (i == 3) ? RGB_MAGENTA : RGB_CYAN;
         exp_q.push_back(mk(3'b001, col[0]));
         tick();
         e = exp_q.pop_front();
         checks++;
         if (grant !== e.grant || busy !== e.busy || {RGB_R, RGB_G, RGB_B} !== e.rgb) begin
            errors++;
            $display("FAIL live_color[%0d]: got grant=%b busy=%b rgb=%b, want grant=%b busy=%b rgb=%b",
                     i, grant, busy, {RGB_R, RGB_G, RGB_B}, e.grant, e.busy, e.rgb);
         end
      end
   endtask

   // A lone owner runs far past the hold, then a competitor arrives: the
   // saturated counter must let rotation happen at the very next edge.
   task automatic test_saturation();
      exp_t e;
      apply_reset();
      col[0] = RGB_RED; col[1] = RGB_CYAN; col[2] = RGB_BLUE;
      for (int i = 0; i < 14; i++) begin
         req = (i < 10) ? 3'b001 : 3'b011;
         exp_q.push_back((i < 10) ? mk(3'b001, RGB_RED) : mk(3'b010, RGB_CYAN));
         tick();
         e = exp_q.pop_front();
         checks++;
         if (grant !== e.grant || busy !== e.busy || {RGB_R, RGB_G, RGB_B} !== e.rgb) begin
            errors++;
            $display("FAIL saturation[%0d]: got grant=%b busy=%b rgb=%b, want grant=%b busy=%b rgb=%b",
                     i, grant, busy, {RGB_R, RGB_G, RGB_B}, e.grant, e.busy, e.rgb);
         end
      end
   endtask

`ifdef RGB_LED_PRIORITY_EN
   task automatic test_priority();
      exp_t e;
      apply_reset();
      col[0] = RGB_RED; col[1] = RGB_GREEN; col[2] = RGB_BLUE;
      for (int i = 0; i < 11; i++) begin
         // 0-1: owner 1. 2: alert preempts at hold_cnt=1. 3-8: alert holds
         // past the hold time. 9-10: alert drops, requester 1 resumes.
         req = (i < 2) ? 3'b010 : (i == 2) ? 3'b011 : (i < 9) ? 3'b111 : 3'b110;
         exp_q.push_back((i < 2 || i >= 9) ? mk(3'b010, RGB_GREEN) : mk(3'b001, RGB_RED));
         tick();
         e = exp_q.pop_front();
         checks++;
         if (grant !== e.grant || busy !== e.busy || {RGB_R, RGB_G, RGB_B} !== e.rgb) begin
            errors++;
            $display("FAIL priority[%0d]: got grant=%b busy=%b rgb=%b, want grant=%b busy=%b rgb=%b",
                     i, grant, busy, {RGB_R, RGB_G, RGB_B}, e.grant, e.busy, e.rgb);
         end
      end
   endtask
`endif

   initial begin
      rst = 1'b1;
      req = 3'b000;
      col[0] = RGB_OFF; col[1] = RGB_OFF; col[2] = RGB_OFF;
      test_reset();
      test_single();
      test_rotation();
      test_early_release();
      test_live_color();
      test_saturation();
`ifdef RGB_LED_PRIORITY_EN
      test_priority();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
